gtz_tone_detector: RTL
======================

Name: gtz_tone_detector

Overview:
- Goertzel single-bin tone analyzer; the receive-side counterpart of the DDS generator.
- Consumes one signed sample per sample-timer strobe and runs the Goertzel recursion over a programmable block of N samples.
- Outputs the squared magnitude at the programmed bin.
- Sits on the same AXI register map and sample timer as the other DSP IPs; used for loopback self-test and tone detection.

Parameters:
SIG_WIDTH, 16, input sample width (signed)
ACC_WIDTH, 32, Goertzel state width s1/s2 (signed)
COEFF_FRAC, 14, fractional bits of coefficient (Q2.14)

Ports:
clk  in  1  clock
a_rst_n  in  1  asynchronous active-low reset
i_gtz_ctrl_reg  in  32  bit0 soft reset, bit1 start (level)
i_gtz_coeff_reg  in  32  [15:0] signed Q2.14 coefficient, 2*cos(2*pi*k/N)
i_gtz_lngth_reg  in  32  [15:0] block length N
i_gtz_sample_en  in  1  sample strobe from sample timer
i_gtz_sample  in  SIG_WIDTH  signed input sample
o_gtz_power  out  2*ACC_WIDTH  signed power result, held until next result
o_gtz_valid  out  1  one-cycle pulse, result updated
o_gtz_busy  out  1  high in ACCUM/CALC1..3
o_gtz_ovrn_cnt  out  8  dropped-sample counter (optional feature)

Behaviour:
- Single clock domain. Async reset clears all state. All outputs reset to 0 and state to IDLE.
- Soft reset (ctrl bit0) is synchronous and has top priority: same clearing as async reset, state IDLE, any block in progress is discarded.
- States: IDLE, ACCUM, CALC1, CALC2, CALC3, DONE.
- IDLE -> ACCUM when start=1 and N!=0.
  - On entry, latch N and coeff; clear s1, s2 and sample count.
  - start=1 with N=0: stay IDLE, busy=0.
- ACCUM, per accepted sample (sample_en=1):
  - p = (coeff*s1) >>> COEFF_FRAC (arithmetic), truncated to ACC_WIDTH.
  - s1 <= sext(x) + p - s2, wrap-around two's complement.
  - s2 <= s1; count++.
  - A sample_en in the IDLE->ACCUM transition cycle is not accepted.
- Acceptance of the Nth sample (edge E0) -> CALC1.
  - Edge E1 latches t1 = s1*s1.
  - Edge E2 latches t2 = s2*s2.
  - Edge E3 latches t3 = p12*s2, where p12 = (coeff*s1)>>>COEFF_FRAC truncated to ACC_WIDTH, and registers o_gtz_power = t1+t2-t3 (2*ACC_WIDTH, wrap) -> DONE.
  - One shared ACC_WIDTH x ACC_WIDTH multiplier serves CALC1..3; a separate 16 x ACC_WIDTH multiplier serves the recursion.
- DONE: o_gtz_valid=1 for exactly this one cycle.
  - Next state ACCUM (continuous mode, cleared as on entry) if start=1 and N!=0, else IDLE.
- sample_en in CALC1..3 or DONE: sample dropped; recursion unaffected.
- start deasserted mid-ACCUM or mid-CALC: the current block completes and its result is still produced.
- Coeff/length register changes take effect only at the next block start.

Optional Feature:
- GTZ_OVRN_CNT_EN defined:
  - o_gtz_ovrn_cnt increments (saturating at 255) on every sample_en while in CALC1..3 or DONE.
  - Cleared by reset, soft reset, or IDLE->ACCUM.
- Undefined: o_gtz_ovrn_cnt tied to 0 and no counter logic is built.

Decomposition:
- gtz_pkg holds:
  - state enum gtz_state_t;
  - GTZ_RST_BIT=0, GTZ_STRT_BIT=1;
  - COEFF_FRAC default;
  - lengths of the coeff and length fields.
- One sub-module, gtz_power_calc: the CALC1..3 sequencer with the shared multiplier and power register. It takes s1, s2 and coeff plus a go pulse, and returns power and done.

Test Plan:
- coeff=0, N=4, x=1000,0,-1000,0 with start=1 then start=0 -> one o_gtz_valid pulse, o_gtz_power=4000000, valid 3 edges after the 4th accepted sample, busy drops with DONE.
- coeff=0, N=4, constant x=1000 -> o_gtz_power=0.
- Continuous mode: start held, repeated tone 1000,0,-1000,0 with sample_en every 4 clocks -> consecutive valid pulses each reporting 4000000.
- Soft reset pulse after 2 of 4 samples -> state IDLE, o_gtz_power=0, no valid; rerun from start gives 4000000.
- start=1 with N=0 -> busy stays 0, no valid for 100 cycles.
- GTZ_OVRN_CNT_EN, N=4, sample_en every cycle, single block -> 4 samples dropped during CALC1..DONE, o_gtz_ovrn_cnt=4; saturates at 255 under sustained overrun in continuous mode.

Source files
------------

// File: rtl/gtz_pkg.sv
// Shared definitions for the Goertzel tone detector: FSM state type,
// control-register bit positions and register field widths.
package gtz_pkg;

    // Block-processing states of the detector.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_CALC1 = 3'd2,
        ST_CALC2 = 3'd3,
        ST_CALC3 = 3'd4,
        ST_DONE  = 3'd5
    } gtz_state_t;

    // Control register bit positions.
    localparam int GTZ_RST_BIT  = 0;
    localparam int GTZ_STRT_BIT = 1;

    // Coefficient format is Q2.14 by default.
    localparam int GTZ_COEFF_FRAC = 14;

    // Used widths of the coefficient and block-length register fields.
    localparam int GTZ_COEFF_LEN = 16;
    localparam int GTZ_LNGTH_LEN = 16;

    // True while a finished block is being evaluated or reported; samples
    // arriving in these states cannot enter the recursion.
    function automatic logic gtz_is_post_accum(input gtz_state_t st);
        return (st == ST_CALC1) || (st == ST_CALC2) ||
               (st == ST_CALC3) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/gtz_power_calc.sv
// Final-power sequencer for the Goertzel detector. After a go pulse it
// spends three cycles on one shared ACC_WIDTH x ACC_WIDTH multiplier:
//   cycle 1: t1 = s1*s1, cycle 2: t2 = s2*s2, cycle 3: p12*s2,
// and on the third edge registers power = t1 + t2 - p12*s2 with a done pulse.
// s1, s2 and p12 must stay stable for the three cycles.
module gtz_power_calc
    import gtz_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          a_rst_n,
    input  logic                          srst_i,
    input  logic                          go_i,
    input  logic signed [ACC_WIDTH-1:0]   s1_i,
    input  logic signed [ACC_WIDTH-1:0]   s2_i,
    input  logic signed [ACC_WIDTH-1:0]   p12_i,
    output logic signed [2*ACC_WIDTH-1:0] power_o,
    output logic                          done_o
);

    localparam int PW = 2 * ACC_WIDTH;

    logic [1:0]           phase_q;
    logic signed [PW-1:0] t1_q;
    logic signed [PW-1:0] t2_q;
    logic signed [PW-1:0] power_q;
    logic                 done_q;

    logic signed [ACC_WIDTH-1:0] mul_a;
    logic signed [ACC_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]        mul_y;

    // Operand steering for the single shared multiplier.
    always_comb begin
        mul_a = s1_i;
        mul_b = s1_i;
        case (phase_q)
            2'd1: begin
                mul_a = s2_i;
                mul_b = s2_i;
            end
            2'd2: begin
                mul_a = p12_i;
                mul_b = s2_i;
            end
            default: begin
                mul_a = s1_i;
                mul_b = s1_i;
            end
        endcase
    end

    assign mul_y = PW'(mul_a) * PW'(mul_b);

    // Three-step product sequence; the last step forms the power in place
    // of a separate t3 register.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            phase_q <= 2'd0;
            t1_q    <= '0;
            t2_q    <= '0;
            power_q <= '0;
            done_q  <= 1'b0;
        end else if (srst_i) begin
            phase_q <= 2'd0;
            t1_q    <= '0;
            t2_q    <= '0;
            power_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                2'd0: begin
                    if (go_i) begin
                        t1_q    <= mul_y;
                        phase_q <= 2'd1;
                    end
                end
                2'd1: begin
                    t2_q    <= mul_y;
                    phase_q <= 2'd2;
                end
                2'd2: begin
                    power_q <= t1_q + t2_q - mul_y;
                    done_q  <= 1'b1;
                    phase_q <= 2'd0;
                end
                default: phase_q <= 2'd0;
            endcase
        end
    end

    assign power_o = power_q;
    assign done_o  = done_q;

endmodule

// File: rtl/gtz_tone_detector.sv
// Goertzel single-bin tone detector. Runs the Goertzel recursion over a
// programmable block of N samples and reports the squared magnitude at the
// programmed bin. Optional dropped-sample counter: define GTZ_OVRN_CNT_EN.
module gtz_tone_detector
    import gtz_pkg::*;
#(
    parameter int SIG_WIDTH  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int COEFF_FRAC = GTZ_COEFF_FRAC
) (
    input  logic                          clk,
    input  logic                          a_rst_n,
    input  logic [31:0]                   i_gtz_ctrl_reg,
    input  logic [31:0]                   i_gtz_coeff_reg,
    input  logic [31:0]                   i_gtz_lngth_reg,
    input  logic                          i_gtz_sample_en,
    input  logic signed [SIG_WIDTH-1:0]   i_gtz_sample,
    output logic signed [2*ACC_WIDTH-1:0] o_gtz_power,
    output logic                          o_gtz_valid,
    output logic                          o_gtz_busy,
    output logic [7:0]                    o_gtz_ovrn_cnt
);

    localparam int RW = GTZ_COEFF_LEN + ACC_WIDTH;

    logic                            soft_rst;
    logic                            start;
    logic signed [GTZ_COEFF_LEN-1:0] coeff_in;
    logic [GTZ_LNGTH_LEN-1:0]        len_in;
    logic                            block_start;

    gtz_state_t                      state_q;
    logic signed [GTZ_COEFF_LEN-1:0] coeff_q;
    logic [GTZ_LNGTH_LEN-1:0]        len_q;
    logic [GTZ_LNGTH_LEN-1:0]        cnt_q;
    logic signed [ACC_WIDTH-1:0]     s1_q;
    logic signed [ACC_WIDTH-1:0]     s2_q;
    logic                            busy_q;

    logic signed [RW-1:0]        rec_prod;
    logic signed [ACC_WIDTH-1:0] p_rec;
    logic signed [ACC_WIDTH-1:0] x_ext;
    logic signed [ACC_WIDTH-1:0] s1_d;

    logic                            calc_go;
    logic signed [2*ACC_WIDTH-1:0]   calc_power;
    logic                            calc_done;
    logic                            unused_bits;

    assign soft_rst    = i_gtz_ctrl_reg[GTZ_RST_BIT];
    assign start       = i_gtz_ctrl_reg[GTZ_STRT_BIT];
    assign coeff_in    = i_gtz_coeff_reg[GTZ_COEFF_LEN-1:0];
    assign len_in      = i_gtz_lngth_reg[GTZ_LNGTH_LEN-1:0];
    assign block_start = start && (len_in != '0);

    // Recursion datapath: the Q2.14 product is rescaled by taking the bit
    // window above the fraction, which equals an arithmetic shift followed
    // by truncation to ACC_WIDTH.
    assign rec_prod = RW'(coeff_q) * RW'(s1_q);
    assign p_rec    = rec_prod[ACC_WIDTH+COEFF_FRAC-1:COEFF_FRAC];
    assign x_ext    = {{(ACC_WIDTH-SIG_WIDTH){i_gtz_sample[SIG_WIDTH-1]}}, i_gtz_sample};
    assign s1_d     = x_ext + p_rec - s2_q;

    // Block sequencer: latch config at block start, run the recursion on
    // accepted samples, then hand the final state to the power calculator.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= ST_IDLE;
            coeff_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            busy_q  <= 1'b0;
        end else if (soft_rst) begin
            state_q <= ST_IDLE;
            coeff_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (block_start) begin
                        state_q <= ST_ACCUM;
                        coeff_q <= coeff_in;
                        len_q   <= len_in;
                        cnt_q   <= '0;
                        s1_q    <= '0;
                        s2_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (i_gtz_sample_en) begin
                        s1_q  <= s1_d;
                        s2_q  <= s1_q;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1) begin
                            state_q <= ST_CALC1;
                        end
                    end
                end
                ST_CALC1: state_q <= ST_CALC2;
                ST_CALC2: state_q <= ST_CALC3;
                ST_CALC3: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                end
                ST_DONE: begin
                    if (block_start) begin
                        state_q <= ST_ACCUM;
                        coeff_q <= coeff_in;
                        len_q   <= len_in;
                        cnt_q   <= '0;
                        s1_q    <= '0;
                        s2_q    <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // s1, s2 and coeff are frozen during CALC1..3, so the recursion product
    // already holds p12 and is reused instead of a third multiplier.
    assign calc_go = (state_q == ST_CALC1);

    gtz_power_calc #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_power_calc (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .srst_i  (soft_rst),
        .go_i    (calc_go),
        .s1_i    (s1_q),
        .s2_i    (s2_q),
        .p12_i   (p_rec),
        .power_o (calc_power),
        .done_o  (calc_done)
    );

    assign o_gtz_power = calc_power;
    assign o_gtz_valid = calc_done;
    assign o_gtz_busy  = busy_q;

`ifdef GTZ_OVRN_CNT_EN
    logic [7:0] ovrn_q;

    // Count samples that arrive while a finished block is being evaluated;
    // saturates so a long overrun never wraps back to a small number.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            ovrn_q <= '0;
        end else if (soft_rst) begin
            ovrn_q <= '0;
        end else if ((state_q == ST_IDLE) && block_start) begin
            ovrn_q <= '0;
        end else if (i_gtz_sample_en && gtz_is_post_accum(state_q) && (ovrn_q != 8'hFF)) begin
            ovrn_q <= ovrn_q + 8'd1;
        end
    end

    assign o_gtz_ovrn_cnt = ovrn_q;
`else
    assign o_gtz_ovrn_cnt = '0;
`endif

    // Register bits outside the used fields and product bits outside the
    // rescaling window are intentionally ignored.
    assign unused_bits = ^{i_gtz_ctrl_reg[31:2],
                           i_gtz_coeff_reg[31:GTZ_COEFF_LEN],
                           i_gtz_lngth_reg[31:GTZ_LNGTH_LEN],
                           rec_prod[COEFF_FRAC-1:0],
                           rec_prod[RW-1:ACC_WIDTH+COEFF_FRAC]};

endmodule
